// File: rtl/swipt_bridge_pwm.sv
`default_nettype none
// ============================================================================
// Module   : swipt_bridge_pwm
// Purpose  : Converts a requested switching frequency (Hz) and duty fraction
//            into dead-time-protected high/low gate pairs for NCH
//            phase-shifted bridge legs. Config updates arrive on a
//            valid/ready handshake. The period comes from an iterative
//            restoring divider and is range checked. Accepted configs are
//            applied glitch-free at the carrier period boundary.
// Revision : 1.0 - initial release
// ============================================================================
module swipt_bridge_pwm #(
    parameter int CLK_HZ = 100_000_000,
    parameter int FREQ_W = 20,
    parameter int DUTY_W = 12,
    parameter int CNT_W  = 24,
    parameter int NCH    = 2,
    parameter int DEAD   = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [FREQ_W-1:0] freq_in,
    input  logic [DUTY_W-1:0] duty_in,
    output logic [NCH-1:0]    pwm_h,
    output logic [NCH-1:0]    pwm_l,
    output logic [CNT_W-1:0]  period_out,
    output logic              active,
    output logic              err
);

    // Quotient width: enough bits to hold CLK_HZ / 1.
    localparam int C_QW  = $clog2(CLK_HZ + 1);
    localparam int C_BW  = $clog2(C_QW + 1);
    localparam int C_LGN = (NCH > 1) ? $clog2(NCH) : 0;
    localparam int C_PW  = CNT_W + DUTY_W;
    localparam int C_OW  = CNT_W + 8;

    localparam logic [C_QW-1:0]  C_DIVIDEND = C_QW'(CLK_HZ);
    localparam logic [63:0]      C_P_LIMIT  = 64'd1 << CNT_W;
    localparam logic [63:0]      C_P_MIN    = 64'(2 * DEAD + 2);
    localparam logic [CNT_W:0]   C_DEAD     = (CNT_W + 1)'(DEAD);
    localparam logic [C_BW-1:0]  C_BIT_LAST = C_BW'(C_QW - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_CHK  = 2'd2;
    localparam logic [1:0] S_PEND = 2'd3;

    // ------------------------------------------------------------------
    // Update pipeline state
    // ------------------------------------------------------------------
    logic [1:0]              r_state;
    logic [FREQ_W-1:0]       r_freq;
    logic [DUTY_W-1:0]       r_duty;
    logic [C_QW-1:0]         r_dvd;
    logic [C_QW-1:0]         r_quot;
    logic [FREQ_W-1:0]       r_rem;
    logic [C_BW-1:0]         r_bit;

    // Staged config waiting for the period boundary
    logic [CNT_W-1:0]            r_per_nxt;
    logic [CNT_W-1:0]            r_th_nxt;
    logic [NCH-1:0][CNT_W-1:0]   r_off_nxt;

    // Live config and carrier
    logic [CNT_W-1:0]            r_th;
    logic [NCH-1:0][CNT_W-1:0]   r_off;
    logic [CNT_W-1:0]            r_cnt;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [FREQ_W:0]             w_trial;
    logic [FREQ_W:0]             w_diff;
    logic                        w_qbit;
    logic [FREQ_W-1:0]           w_rem_next;
    logic [63:0]                 w_quot64;
    logic                        w_reject;
    logic [CNT_W-1:0]            w_p;
    logic [C_PW-1:0]             w_prod;
    logic [CNT_W-1:0]            w_th;
    logic [NCH-1:0][CNT_W-1:0]   w_off_calc;
    logic                        w_run;
    logic                        w_wrap;
    logic                        w_apply;
    logic [CNT_W:0]              w_thd;
    logic [NCH-1:0]              w_h_nxt;
    logic [NCH-1:0]              w_l_nxt;

    assign upd_ready = (r_state == S_IDLE);

    // One restoring-division step: shift in the next dividend bit, then
    // subtract the divisor if it fits.
    assign w_trial    = {r_rem, r_dvd[C_QW-1]};
    assign w_diff     = w_trial - {1'b0, r_freq};
    assign w_qbit     = (w_trial >= {1'b0, r_freq});
    assign w_rem_next = w_qbit ? w_diff[FREQ_W-1:0] : w_trial[FREQ_W-1:0];

    // Range check on the finished quotient.
    assign w_quot64 = 64'(r_quot);
    assign w_reject = (r_freq == '0) || (w_quot64 >= C_P_LIMIT) || (w_quot64 < C_P_MIN);
    assign w_p      = w_quot64[CNT_W-1:0];

    // High-side threshold: P*duty scaled down by the duty resolution.
    assign w_prod = C_PW'(w_p) * C_PW'(r_duty);
    assign w_th   = CNT_W'(w_prod >> DUTY_W);

    // Phase offsets: leg k starts k/NCH of a period later.
    for (genvar k = 0; k < NCH; k++) begin : g_off
        logic [C_OW-1:0] w_pk;
        assign w_pk          = C_OW'(w_p) * C_OW'(k);
        assign w_off_calc[k] = CNT_W'(w_pk >> C_LGN);
    end

    // Carrier control
    assign w_run   = en && active;
    assign w_wrap  = (r_cnt == (period_out - CNT_W'(1)));
    assign w_apply = (r_state == S_PEND) && (!active || !en || w_wrap);

    // Per-leg phase and gate windows, evaluated one cycle ahead of the pins.
    assign w_thd = {1'b0, r_th} + C_DEAD;

    for (genvar k = 0; k < NCH; k++) begin : g_leg
        logic [CNT_W:0] w_sum;
        logic [CNT_W:0] w_ph;
        assign w_sum      = {1'b0, r_cnt} + {1'b0, r_off[k]};
        assign w_ph       = (w_sum >= {1'b0, period_out}) ? (w_sum - {1'b0, period_out}) : w_sum;
        assign w_h_nxt[k] = (w_ph >= C_DEAD) && (w_ph < {1'b0, r_th});
        assign w_l_nxt[k] = (w_ph >= w_thd) && (w_ph < {1'b0, period_out});
    end

    // Update FSM: latch request, divide, range check, then wait to apply.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= S_IDLE;
            r_freq    <= '0;
            r_duty    <= '0;
            r_dvd     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_bit     <= '0;
            r_per_nxt <= '0;
            r_th_nxt  <= '0;
            r_off_nxt <= '0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (upd_valid) begin
                        r_freq <= freq_in;
                        r_duty <= duty_in;
                        r_dvd  <= C_DIVIDEND;
                        r_quot <= '0;
                        r_rem  <= '0;
                        r_bit  <= C_BIT_LAST;
                        // A zero frequency cannot be divided; let the
                        // check stage reject it straight away.
                        r_state <= (freq_in == '0) ? S_CHK : S_DIV;
                    end
                end
                S_DIV: begin
                    r_rem  <= w_rem_next;
                    r_dvd  <= r_dvd << 1;
                    r_quot <= {r_quot[C_QW-2:0], w_qbit};
                    if (r_bit == '0) begin
                        r_state <= S_CHK;
                    end else begin
                        r_bit <= r_bit - C_BW'(1);
                    end
                end
                S_CHK: begin
                    if (w_reject) begin
                        err     <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_per_nxt <= w_p;
                        r_th_nxt  <= w_th;
                        r_off_nxt <= w_off_calc;
                        r_state   <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (w_apply) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Live config swaps only when the staged one is released.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            period_out <= '0;
            r_th       <= '0;
            r_off      <= '0;
            active     <= 1'b0;
        end else if (w_apply) begin
            period_out <= r_per_nxt;
            r_th       <= r_th_nxt;
            r_off      <= r_off_nxt;
            active     <= 1'b1;
        end
    end

    // Carrier counter: held at zero while stopped, wraps at the period end.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= '0;
        end else if (!w_run || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Registered gate drivers, forced low whenever the carrier is stopped.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pwm_h <= '0;
            pwm_l <= '0;
        end else if (w_run) begin
            pwm_h <= w_h_nxt;
            pwm_l <= w_l_nxt;
        end else begin
            pwm_h <= '0;
            pwm_l <= '0;
        end
    end

endmodule
`default_nettype wire
